// File: rtl/fft_pkg.sv
// Shared types and constants for the IFFT cyclic-prefix inserter.
// Holds the symbol size, sample width, bank address width, the complex
// sample struct, both FSM state enums and the rounding/saturation helper
// used when CPINS_ROUND_SHIFT_EN is defined.
package fft_pkg;

  localparam int N_FFT = 32;
  localparam int DW    = 16;
  localparam int AW    = $clog2(N_FFT);

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } cplx_t;

  typedef enum logic {CAP_IDLE, CAP_RUN} cap_state_t;

  typedef enum logic [1:0] {IDLE, CP, BODY} out_state_t;

  // Round-half-up arithmetic right shift in DW+1 bits, then clamp to DW bits.
  function automatic logic signed [DW-1:0] round_sat(input logic signed [DW-1:0] x,
                                                     input int unsigned sh);
    logic signed [DW:0] ext;
    logic signed [DW:0] bias;
    ext  = {x[DW-1], x};
    bias = (sh == 0) ? '0 : $signed((DW+1)'(1) << (sh - 1));
    ext  = (ext + bias) >>> sh;
    if (ext[DW] != ext[DW-1]) begin
      return ext[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end
    return ext[DW-1:0];
  endfunction

endpackage

// File: rtl/cpins_bank_ram.sv
// Two-bank sample store: 2*N_FFT words of one complex sample each.
// The bank bit is the address MSB. One write port and one registered
// read port; the read register holds its value while re is low so the
// consumer can stall without losing the prefetched word.
module cpins_bank_ram
  import fft_pkg::*;
#(
  parameter int ADDR_W = AW,
  parameter int WORD_W = 2 * DW
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W:0]   waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W:0]   raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [2**(ADDR_W+1)];

  // Write port: one sample per enabled edge.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port; holds on re = 0.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ifft_cp_inserter.sv
// Cyclic-prefix inserter behind the 32-point IFFT.
// Captures each 32-sample burst into one of two ping-pong banks and
// replays it as CP_LEN prefix samples followed by the full symbol on a
// valid/ready stream. Optional output rounding: CPINS_ROUND_SHIFT_EN.
//
// Handshake: a beat transfers on a clock edge where out_valid & out_ready.
// Once out_valid is high it stays high, with out_real/out_imag/out_sof/
// out_eof unchanged, until that beat transfers.
module ifft_cp_inserter
  import fft_pkg::*;
#(
  parameter int CP_LEN    = 8,
  parameter int OUT_SHIFT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          fft_done,
  input  logic [DW-1:0] data_real_in,
  input  logic [DW-1:0] data_imag_in,
  output logic [DW-1:0] out_real,
  output logic [DW-1:0] out_imag,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sof,
  output logic          out_eof,
  output logic          overflow
);

  if (CP_LEN < 1 || CP_LEN >= N_FFT || OUT_SHIFT < 0) begin : g_bad_cfg
    $error("ifft_cp_inserter: CP_LEN must be in [1, N_FFT) and OUT_SHIFT >= 0");
  end

  // ---------------- capture side ----------------
  logic         fft_done_q, start;
  cap_state_t   cap_state, cap_next;
  logic [AW-1:0] wcnt, waddr;
  logic         wbank, we, set_full, drop, wbank_empty;
  logic [1:0]   full;

  // ---------------- read side ----------------
  out_state_t   out_state, out_next;
  logic [AW:0]  rcnt;
  logic [AW-1:0] raddr;
  logic         rbank, issue, iss_sof, iss_eof, last_cp, free;
  logic         s1_valid, s1_sof, s1_eof, adv_out, adv_s1;
  cplx_t        wr_word, rd_word, shaped;

  assign start       = fft_done & ~fft_done_q;
  assign adv_out     = ~out_valid | out_ready;
  assign adv_s1      = ~s1_valid | adv_out;
  assign free        = out_valid & out_ready & out_eof;
  // A bank released on this very edge can take the new burst.
  assign wbank_empty = ~full[wbank] | (free & (rbank == wbank));
  assign wr_word     = '{re: data_real_in, im: data_imag_in};

  cpins_bank_ram u_ram (
    .clk   (clk),
    .we    (we),
    .waddr ({wbank, waddr}),
    .wdata (wr_word),
    .re    (issue),
    .raddr ({rbank, raddr}),
    .rdata (rd_word)
  );

  // Capture state register.
  always_ff @(posedge clk) begin
    if (reset) cap_state <= CAP_IDLE;
    else       cap_state <= cap_next;
  end

  // Capture next state: run for exactly N_FFT samples once a burst is accepted.
  always_comb begin
    cap_next = cap_state;
    case (cap_state)
      CAP_IDLE: if (start && wbank_empty) cap_next = CAP_RUN;
      CAP_RUN:  if (wcnt == AW'(N_FFT - 1)) cap_next = CAP_IDLE;
      default:  cap_next = CAP_IDLE;
    endcase
  end

  // Capture outputs: write strobe/address, bank completion, dropped burst.
  always_comb begin
    we       = 1'b0;
    waddr    = wcnt;
    set_full = 1'b0;
    drop     = 1'b0;
    case (cap_state)
      CAP_IDLE: begin
        if (start && wbank_empty) begin
          we    = 1'b1;
          waddr = '0;
        end else if (start) begin
          drop = 1'b1;
        end
      end
      CAP_RUN: begin
        we       = 1'b1;
        set_full = (wcnt == AW'(N_FFT - 1));
        drop     = start;
      end
      default: ;
    endcase
  end

  // Capture datapath: edge detect, sample counter, write bank, overflow pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      fft_done_q <= 1'b0;
      wcnt       <= '0;
      wbank      <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      fft_done_q <= fft_done;
      overflow   <= drop;
      if (cap_state == CAP_IDLE && we) wcnt <= AW'(1);
      else if (cap_state == CAP_RUN)   wcnt <= wcnt + AW'(1);
      if (set_full) wbank <= ~wbank;
    end
  end

  // Bank occupancy: cleared when the eof beat leaves, set when capture completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      full <= 2'b00;
    end else begin
      if (free)     full[rbank] <= 1'b0;
      if (set_full) full[wbank] <= 1'b1;
    end
  end

  // Output state register.
  always_ff @(posedge clk) begin
    if (reset) out_state <= IDLE;
    else       out_state <= out_next;
  end

  // Output next state: prefix, then body, then wait for eof to be accepted.
  always_comb begin
    out_next = out_state;
    case (out_state)
      IDLE, CP: if (issue) out_next = last_cp ? BODY : CP;
      BODY:     if (free) out_next = IDLE;
      default:  out_next = IDLE;
    endcase
  end

  // Output FSM outputs: RAM read issue. IDLE already fetches the first
  // prefix sample so out_valid rises two cycles after the bank fills.
  always_comb begin
    issue   = 1'b0;
    raddr   = rcnt[AW-1:0];
    iss_sof = 1'b0;
    iss_eof = 1'b0;
    case (out_state)
      IDLE: begin
        if (full[rbank] && adv_s1) begin
          issue   = 1'b1;
          raddr   = AW'(N_FFT - CP_LEN);
          iss_sof = 1'b1;
        end
      end
      CP:   issue = adv_s1;
      BODY: begin
        issue   = adv_s1 & ~rcnt[AW];
        iss_eof = (rcnt[AW-1:0] == AW'(N_FFT - 1));
      end
      default: ;
    endcase
    last_cp = (raddr == AW'(N_FFT - 1));
  end

  // Read counter and read bank; rcnt reaching N_FFT in BODY means all issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      rcnt  <= '0;
      rbank <= 1'b0;
    end else begin
      if (issue) begin
        if (out_state == BODY) rcnt <= rcnt + (AW+1)'(1);
        else if (last_cp)      rcnt <= '0;
        else                   rcnt <= {1'b0, raddr} + (AW+1)'(1);
      end
      if (free) rbank <= ~rbank;
    end
  end

`ifdef CPINS_ROUND_SHIFT_EN
  assign shaped = '{re: round_sat(rd_word.re, OUT_SHIFT), im: round_sat(rd_word.im, OUT_SHIFT)};
`else
  assign shaped = rd_word;
`endif

  // Two-stage read pipeline: RAM register (s1) feeding the output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_sof    <= 1'b0;
      s1_eof    <= 1'b0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      out_real  <= '0;
      out_imag  <= '0;
    end else begin
      if (adv_s1) begin
        s1_valid <= issue;
        s1_sof   <= iss_sof;
        s1_eof   <= iss_eof;
      end
      if (adv_out) begin
        out_valid <= s1_valid;
        out_sof   <= s1_valid & s1_sof;
        out_eof   <= s1_valid & s1_eof;
        out_real  <= shaped.re;
        out_imag  <= shaped.im;
      end
    end
  end

endmodule

// File: tb/tb_ifft_cp_inserter.sv
// Self-checking bench for ifft_cp_inserter: a table of burst scenarios
// (ramp, back-pressure, ping-pong, overflow, reset, random) driven cycle
// by cycle, with a queue-based model predicting every output beat.
module tb_ifft_cp_inserter;
  import fft_pkg::*;

  localparam int CPL   = 8;
  localparam int SH    = 1;
  localparam int EW    = 2 * DW + 2;
  localparam int MAXB  = 4;
  localparam int LIMIT = 1500;

  typedef struct {
    int nb;        // bursts
    int gap;       // cycles between burst starts
    int mode;      // 0 ready=1, 1 pattern 1,0,0, 2 held low until captured, 3 random
    int data;      // 0 ramp, 1 random, 2 corner values
    int reset_at;  // cycle index of a one-cycle reset, -1 for none
    int exp_beats; // -1: not fixed
    int exp_ovf;   // -1: not fixed
  } scn_t;

  logic          clk = 1'b0;
  logic          reset, fft_done, out_ready;
  logic [DW-1:0] din_re, din_im, out_real, out_imag;
  logic          out_valid, out_sof, out_eof, overflow;

  ifft_cp_inserter #(.CP_LEN(CPL), .OUT_SHIFT(SH)) dut (
    .clk          (clk),
    .reset        (reset),
    .fft_done     (fft_done),
    .data_real_in (din_re),
    .data_imag_in (din_im),
    .out_real     (out_real),
    .out_imag     (out_imag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sof      (out_sof),
    .out_eof      (out_eof),
    .overflow     (overflow)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] bre [MAXB][N_FFT];
  logic [DW-1:0] bim [MAXB][N_FFT];
  logic [EW-1:0] exp_q[$];
  int            cur_burst = 0;
  int            pending = 0, beats_seen = 0, ovf_seen = 0, first_valid = -1;
  logic          prev_fd = 1'b0, ovf_due = 1'b0, hold_prev = 1'b0;
  logic [EW-1:0] held;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Output-stage transform from the sample rules, in plain integer arithmetic.
  function automatic logic [DW-1:0] xf(input logic [DW-1:0] x);
`ifdef CPINS_ROUND_SHIFT_EN
    int v;
    v = int'($signed(x));
    v = (v + (1 << (SH - 1))) >>> SH;
    if (v > (1 << (DW - 1)) - 1) v = (1 << (DW - 1)) - 1;
    if (v < -(1 << (DW - 1)))    v = -(1 << (DW - 1));
    return DW'(v);
`else
    return x;
`endif
  endfunction

  // Expected symbol: last CPL samples, then all N_FFT samples.
  task automatic push_symbol(input int b);
    int idx;
    for (int k = 0; k < CPL + N_FFT; k++) begin
      idx = (k < CPL) ? (N_FFT - CPL + k) : (k - CPL);
      exp_q.push_back({k == 0, k == CPL + N_FFT - 1, xf(bre[b][idx]), xf(bim[b][idx])});
    end
  endtask

  // Scoreboard/monitor on the falling edge: predicts the edge that follows.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      pending   = 0;
      prev_fd   = 1'b0;
      ovf_due   = 1'b0;
      hold_prev = 1'b0;
    end else begin
      chk("overflow", overflow, ovf_due);
      ovf_due = 1'b0;
      if (overflow) ovf_seen++;
      if (hold_prev) begin
        chk("stall_valid", out_valid, 1'b1);
        chk("stall_data", {out_sof, out_eof, out_real, out_imag}, held);
      end
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (out_valid && out_ready) begin
        beats_seen++;
        chk("beat_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0)
          chk("beat", {out_sof, out_eof, out_real, out_imag}, exp_q.pop_front());
        if (out_eof && pending > 0) pending--;
      end
      if (fft_done && !prev_fd) begin
        if (pending < 2) begin
          pending++;
          push_symbol(cur_burst);
        end else begin
          ovf_due = 1'b1;
        end
      end
      prev_fd   = fft_done;
      hold_prev = out_valid && !out_ready;
      held      = {out_sof, out_eof, out_real, out_imag};
    end
  end

  // Driver: bursts, ready pattern and optional reset, one iteration per cycle.
  task automatic run_scn(input scn_t s, input int id);
    logic [DW-1:0] corner[4];
    int t, st, last_start, c31, v;
    bit done, abandoned;
    corner = '{16'h7fff, 16'h0003, 16'hfffd, 16'h8000};
    beats_seen = 0;
    ovf_seen   = 0;
    first_valid = -1;
    c31 = -1;
    for (int b = 0; b < s.nb; b++) begin
      for (int n = 0; n < N_FFT; n++) begin
        case (s.data)
          0: begin
            v = b * 256 + n;
            bre[b][n] = DW'(v);
            bim[b][n] = DW'(-v);
          end
          1: begin
            bre[b][n] = DW'($urandom);
            bim[b][n] = DW'($urandom);
          end
          default: begin
            bre[b][n] = corner[n % 4];
            bim[b][n] = corner[(n + 1) % 4];
          end
        endcase
      end
    end
    last_start = (s.nb - 1) * s.gap;
    t = 0;
    done = 1'b0;
    while (!done && t < LIMIT) begin
      @(posedge clk);
      #1;
      if (s.reset_at >= 0 && t == s.reset_at + 1) begin
        chk("valid_after_reset", out_valid, 1'b0);
        chk("ovf_after_reset", overflow, 1'b0);
      end
      reset    = (t == s.reset_at);
      fft_done = 1'b0;
      din_re   = '0;
      din_im   = '0;
      for (int b = 0; b < s.nb; b++) begin
        st = b * s.gap;
        abandoned = (s.reset_at >= 0) && (st <= s.reset_at) && (t >= s.reset_at);
        if (t >= st && t < st + N_FFT && !abandoned) begin
          fft_done  = 1'b1;
          cur_burst = b;
          din_re    = bre[b][t - st];
          din_im    = bim[b][t - st];
          if (b == 0 && t - st == N_FFT - 1) c31 = cyc;
        end
      end
      case (s.mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (t % 3 == 0);
        2:       out_ready = (t >= last_start + N_FFT + 2);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      t++;
      if (t > last_start + N_FFT + 4 && exp_q.size() == 0 && !out_valid && !ovf_due && !reset)
        done = 1'b1;
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    chk($sformatf("s%0d_queue_drained", id), exp_q.size(), 0);
    chk($sformatf("s%0d_valid_idle", id), out_valid, 1'b0);
    if (s.exp_beats >= 0) chk($sformatf("s%0d_beats", id), beats_seen, s.exp_beats);
    if (s.exp_ovf >= 0)   chk($sformatf("s%0d_overflows", id), ovf_seen, s.exp_ovf);
    if (s.mode == 0 && s.reset_at < 0)
      chk($sformatf("s%0d_latency_le2", id), (first_valid - (c31 + 1)) <= 2, 1'b1);
  endtask

  scn_t scn[9];

  initial begin
    scn[0] = '{nb: 1, gap: 40, mode: 0, data: 0, reset_at: -1, exp_beats: 40, exp_ovf: 0};
    scn[1] = '{nb: 1, gap: 40, mode: 1, data: 0, reset_at: -1, exp_beats: 40, exp_ovf: 0};
    scn[2] = '{nb: 2, gap: 40, mode: 2, data: 0, reset_at: -1, exp_beats: 80, exp_ovf: 0};
    scn[3] = '{nb: 3, gap: 40, mode: 2, data: 0, reset_at: -1, exp_beats: 80, exp_ovf: 1};
    scn[4] = '{nb: 2, gap: 36, mode: 0, data: 0, reset_at: 46, exp_beats: -1, exp_ovf: 0};
    scn[5] = '{nb: 1, gap: 40, mode: 0, data: 0, reset_at: -1, exp_beats: 40, exp_ovf: 0};
    scn[6] = '{nb: 4, gap: 34, mode: 3, data: 1, reset_at: -1, exp_beats: -1, exp_ovf: -1};
    scn[7] = '{nb: 3, gap: 33, mode: 3, data: 1, reset_at: -1, exp_beats: -1, exp_ovf: -1};
    scn[8] = '{nb: 1, gap: 40, mode: 1, data: 2, reset_at: -1, exp_beats: 40, exp_ovf: 0};

    reset     = 1'b1;
    fft_done  = 1'b0;
    out_ready = 1'b1;
    din_re    = '0;
    din_im    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_sof", out_sof, 1'b0);
    chk("rst_eof", out_eof, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_real", out_real, '0);
    chk("rst_imag", out_imag, '0);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 9; i++) run_scn(scn[i], i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
